// File: rtl/vnu_wr_update_ctrl_mc.sv
// -----------------------------------------------------------------------------
// vnu_wr_update_ctrl_mc
//   Multi-channel VNU write/load sequencer. Each of NUM_CH channels runs its own
//   FSM: accept an init-load or pipe-load request, strobe the matching load
//   output for one cycle, then hold the VNU write enable for WR_HOLD cycles,
//   then wait for a rising edge on its (synchronised) iteration-update level.
//   A per-channel iteration counter stops the channel in DONE after MAX_ITER
//   iterations. Requests that arrive while a channel is busy loading/writing
//   set a sticky error flag.
//
//   Handshake: requests are level-sampled on each rising read_clk edge. A
//   request is consumed only in IDLE. There is no ready back-pressure; a request
//   seen in INIT_LD/PIPE_LD/WR is dropped and flagged in req_err_o.
//
// Ports
//   read_clk            clock, rising edge
//   rst                 asynchronous active-high reset
//   iter_update_i       per-channel iteration-update level (asynchronous)
//   vnu_rd_finish_i     per-channel pipe-load request
//   vnu_init_load_en_i  per-channel initial-load request
//   iter_clr_i          synchronous clear of all channels (highest priority)
//   vnu_wr_o            per-channel VNU write enable
//   init_load_o         per-channel initial-load strobe
//   pipe_load_o         per-channel pipe-load strobe
//   iter_cnt_o          per-channel completed iterations, ch c at [c*ITER_W +: ITER_W]
//   ch_done_o           per-channel reached MAX_ITER
//   all_done_o          all channels done
//   req_err_o           per-channel sticky dropped-request flag
// -----------------------------------------------------------------------------
module vnu_wr_update_ctrl_mc #(
  parameter int NUM_CH     = 4,
  parameter int SYNC_DEPTH = 2,
  parameter int WR_HOLD    = 1,
  parameter int MAX_ITER   = 10,
  parameter int ITER_W     = $clog2(MAX_ITER + 1)
) (
  input  logic                     read_clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        iter_update_i,
  input  logic [NUM_CH-1:0]        vnu_rd_finish_i,
  input  logic [NUM_CH-1:0]        vnu_init_load_en_i,
  input  logic                     iter_clr_i,
  output logic [NUM_CH-1:0]        vnu_wr_o,
  output logic [NUM_CH-1:0]        init_load_o,
  output logic [NUM_CH-1:0]        pipe_load_o,
  output logic [NUM_CH*ITER_W-1:0] iter_cnt_o,
  output logic [NUM_CH-1:0]        ch_done_o,
  output logic                     all_done_o,
  output logic [NUM_CH-1:0]        req_err_o
);

  localparam int HOLD_W = (WR_HOLD > 1) ? $clog2(WR_HOLD) : 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_INIT_LD = 3'd1,
    S_PIPE_LD = 3'd2,
    S_WR      = 3'd3,
    S_WAIT_IT = 3'd4,
    S_DONE    = 3'd5
  } state_e;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic              sync_last;
    logic              prev_q;
    logic              upd_edge;
    logic              req;
    state_e            state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [ITER_W-1:0] cnt_q, cnt_d;
    logic              err_q, err_d;

    if (SYNC_DEPTH == 0) begin : g_nosync
      assign sync_last = iter_update_i[c];
    end else begin : g_sync
      // Shift toward the MSB; the MSB is the synchronised level.
      logic [SYNC_DEPTH-1:0] sync_q;
      always_ff @(posedge read_clk or posedge rst) begin
        if (rst) sync_q <= '0;
        else     sync_q <= SYNC_DEPTH'({sync_q, iter_update_i[c]});
      end
      assign sync_last = sync_q[SYNC_DEPTH-1];
    end

    assign upd_edge = sync_last & ~prev_q;
    assign req      = vnu_init_load_en_i[c] | vnu_rd_finish_i[c];

    always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      case (state_q)
        S_IDLE: begin
          if (vnu_init_load_en_i[c])   state_d = S_INIT_LD;
          else if (vnu_rd_finish_i[c]) state_d = S_PIPE_LD;
        end
        S_INIT_LD, S_PIPE_LD: begin
          if (req) err_d = 1'b1;
          hold_d  = '0;
          state_d = S_WR;
        end
        S_WR: begin
          if (req) err_d = 1'b1;
          if (hold_q == HOLD_W'(WR_HOLD - 1)) begin
            hold_d  = '0;
            state_d = S_WAIT_IT;
          end else begin
            hold_d = hold_q + HOLD_W'(1);
          end
        end
        S_WAIT_IT: begin
          // Leaving WAIT_IT on the final iteration is what keeps cnt saturated.
          if (upd_edge) begin
            cnt_d   = cnt_q + ITER_W'(1);
            state_d = (cnt_q + ITER_W'(1) == ITER_W'(MAX_ITER)) ? S_DONE : S_IDLE;
          end
        end
        S_DONE:  state_d = S_DONE;
        default: state_d = S_IDLE;
      endcase
      if (iter_clr_i) begin
        state_d = S_IDLE;
        hold_d  = '0;
        cnt_d   = '0;
        err_d   = 1'b0;
      end
    end

    always_ff @(posedge read_clk or posedge rst) begin
      if (rst) begin
        state_q <= S_IDLE;
        hold_q  <= '0;
        cnt_q   <= '0;
        err_q   <= 1'b0;
        prev_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        hold_q  <= hold_d;
        cnt_q   <= cnt_d;
        err_q   <= err_d;
        prev_q  <= sync_last;
      end
    end

    // Outputs decode only state registers, so reset clears them instantly.
    assign init_load_o[c]                 = (state_q == S_INIT_LD);
    assign pipe_load_o[c]                 = (state_q == S_PIPE_LD);
    assign vnu_wr_o[c]                    = (state_q == S_WR);
    assign ch_done_o[c]                   = (state_q == S_DONE);
    assign req_err_o[c]                   = err_q;
    assign iter_cnt_o[c*ITER_W +: ITER_W] = cnt_q;
  end

  assign all_done_o = &ch_done_o;

endmodule

// File: tb/tb_vnu_wr_update_ctrl_mc.sv
// -----------------------------------------------------------------------------
// tb_vnu_wr_update_ctrl_mc
//   Directed bench for vnu_wr_update_ctrl_mc. Instance a uses the default
//   parameters (WR_HOLD=1, MAX_ITER=10, SYNC_DEPTH=2); instance b uses
//   WR_HOLD=3, MAX_ITER=2 for the long-write and termination scenarios.
//   Inputs change 1 ns after a rising edge; outputs are sampled at that point.
// -----------------------------------------------------------------------------
module tb_vnu_wr_update_ctrl_mc;

  logic        clk;
  logic        rst;

  logic [3:0]  a_iu, a_rd, a_init;
  logic        a_clr;
  logic [3:0]  a_wr, a_init_o, a_pipe_o, a_done, a_err;
  logic [15:0] a_cnt;
  logic        a_all;

  logic [3:0]  b_iu, b_rd, b_init;
  logic        b_clr;
  logic [3:0]  b_wr, b_init_o, b_pipe_o, b_done, b_err;
  logic [7:0]  b_cnt;
  logic        b_all;

  int n_pass  = 0;
  int n_total = 0;

  vnu_wr_update_ctrl_mc dut_a (
    .read_clk           (clk),
    .rst                (rst),
    .iter_update_i      (a_iu),
    .vnu_rd_finish_i    (a_rd),
    .vnu_init_load_en_i (a_init),
    .iter_clr_i         (a_clr),
    .vnu_wr_o           (a_wr),
    .init_load_o        (a_init_o),
    .pipe_load_o        (a_pipe_o),
    .iter_cnt_o         (a_cnt),
    .ch_done_o          (a_done),
    .all_done_o         (a_all),
    .req_err_o          (a_err)
  );

  vnu_wr_update_ctrl_mc #(.WR_HOLD(3), .MAX_ITER(2)) dut_b (
    .read_clk           (clk),
    .rst                (rst),
    .iter_update_i      (b_iu),
    .vnu_rd_finish_i    (b_rd),
    .vnu_init_load_en_i (b_init),
    .iter_clr_i         (b_clr),
    .vnu_wr_o           (b_wr),
    .init_load_o        (b_init_o),
    .pipe_load_o        (b_pipe_o),
    .iter_cnt_o         (b_cnt),
    .ch_done_o          (b_done),
    .all_done_o         (b_all),
    .req_err_o          (b_err)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  initial begin
    rst = 1'b0;
    a_iu = '0; a_rd = '0; a_init = '0; a_clr = 1'b0;
    b_iu = '0; b_rd = '0; b_init = '0; b_clr = 1'b0;
    #1 rst = 1'b1;
    #1;
    // reset state, before any clock edge
    chk("rst_a_wr",   32'(a_wr),     32'h0);
    chk("rst_a_init", 32'(a_init_o), 32'h0);
    chk("rst_a_pipe", 32'(a_pipe_o), 32'h0);
    chk("rst_a_cnt",  32'(a_cnt),    32'h0);
    chk("rst_a_done", 32'(a_done),   32'h0);
    chk("rst_a_all",  32'(a_all),    32'h0);
    chk("rst_a_err",  32'(a_err),    32'h0);
    chk("rst_b_cnt",  32'(b_cnt),    32'h0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // 1: ch0 init load, WR_HOLD=1
    a_init = 4'b0001;
    tick();
    a_init = 4'b0000;
    chk("t1_init_pulse", 32'(a_init_o), 32'h1);
    chk("t1_wr_early",   32'(a_wr),     32'h0);
    chk("t1_pipe",       32'(a_pipe_o), 32'h0);
    tick();
    chk("t1_init_end",   32'(a_init_o), 32'h0);
    chk("t1_wr_pulse",   32'(a_wr),     32'h1);
    tick();
    chk("t1_wr_end",     32'(a_wr),     32'h0);

    // 2: ch1 init + rd_finish together; init wins, no error
    a_init = 4'b0010; a_rd = 4'b0010;
    tick();
    a_init = 4'b0000; a_rd = 4'b0000;
    chk("t2_init",       32'(a_init_o), 32'h2);
    chk("t2_no_pipe",    32'(a_pipe_o), 32'h0);
    tick();
    chk("t2_wr",         32'(a_wr),     32'h2);
    chk("t2_err",        32'(a_err),    32'h0);
    tick();
    chk("t2_wr_end",     32'(a_wr),     32'h0);

    // 4: ch3 into WAIT_IT, then iter_update held 10 cycles
    a_rd = 4'b1000;
    tick();
    a_rd = 4'b0000;
    chk("t4_pipe",       32'(a_pipe_o), 32'h8);
    tick();
    chk("t4_wr",         32'(a_wr),     32'h8);
    tick();
    a_iu = 4'b1000;
    tick();
    chk("t4_cnt_e1",     32'(a_cnt),    32'h0);
    tick();
    chk("t4_cnt_e2",     32'(a_cnt),    32'h0);
    tick();
    chk("t4_cnt_e3",     32'(a_cnt),    32'h1000);
    for (int i = 0; i < 7; i++) tick();
    a_iu = 4'b0000;
    chk("t4_cnt_held",   32'(a_cnt),    32'h1000);
    chk("t4_no_strobe",  32'(a_init_o | a_pipe_o | a_wr), 32'h0);

    // 3: instance b, ch2 pipe load, WR_HOLD=3, repeat request during WR
    b_rd = 4'b0100;
    tick();
    b_rd = 4'b0000;
    chk("t3_pipe",       32'(b_pipe_o), 32'h4);
    chk("t3_wr_early",   32'(b_wr),     32'h0);
    tick();
    chk("t3_pipe_end",   32'(b_pipe_o), 32'h0);
    chk("t3_wr_c1",      32'(b_wr),     32'h4);
    b_rd = 4'b0100;
    tick();
    b_rd = 4'b0000;
    chk("t3_wr_c2",      32'(b_wr),     32'h4);
    chk("t3_err_set",    32'(b_err),    32'h4);
    tick();
    chk("t3_wr_c3",      32'(b_wr),     32'h4);
    tick();
    chk("t3_wr_end",     32'(b_wr),     32'h0);
    chk("t3_err_sticky", 32'(b_err),    32'h4);
    chk("t3_no_reload",  32'(b_pipe_o), 32'h0);

    // 5: clear, then two full loops on all channels of instance b
    b_clr = 1'b1;
    tick();
    b_clr = 1'b0;
    chk("t5_clr_err",    32'(b_err),    32'h0);
    for (int loop = 0; loop < 2; loop++) begin
      b_init = 4'hF;
      tick();
      b_init = 4'h0;
      chk($sformatf("t5_init_l%0d", loop), 32'(b_init_o), 32'hF);
      tick();
      chk($sformatf("t5_wr_l%0d", loop),   32'(b_wr),     32'hF);
      tick(); tick(); tick();
      b_iu = 4'hF;
      tick(); tick(); tick();
      b_iu = 4'h0;
      chk($sformatf("t5_cnt_l%0d", loop),  32'(b_cnt), (loop == 0) ? 32'h55 : 32'hAA);
      chk($sformatf("t5_done_l%0d", loop), 32'(b_done), (loop == 0) ? 32'h0 : 32'hF);
      tick(); tick(); tick();
    end
    chk("t5_all_done",   32'(b_all),    32'h1);
    b_init = 4'hF; b_rd = 4'hF; b_iu = 4'hF;
    tick();
    b_init = 4'h0; b_rd = 4'h0;
    tick(); tick(); tick();
    b_iu = 4'h0;
    chk("t5_ign_strobe", 32'(b_init_o | b_pipe_o | b_wr), 32'h0);
    chk("t5_ign_err",    32'(b_err),    32'h0);
    chk("t5_ign_cnt",    32'(b_cnt),    32'hAA);
    chk("t5_ign_done",   32'(b_done),   32'hF);
    b_clr = 1'b1;
    tick();
    b_clr = 1'b0;
    chk("t5_clr_cnt",    32'(b_cnt),    32'h0);
    chk("t5_clr_done",   32'(b_done),   32'h0);
    chk("t5_clr_all",    32'(b_all),    32'h0);

    // 6: reset in the middle of a write on instance a ch2
    a_init = 4'b0100;
    tick();
    a_init = 4'b0000;
    tick();
    chk("t6_wr_before",  32'(a_wr),     32'h4);
    rst = 1'b1;
    #1;
    chk("t6_wr_async",   32'(a_wr),     32'h0);
    chk("t6_cnt_async",  32'(a_cnt),    32'h0);
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("t6_post_strb",  32'(a_init_o | a_pipe_o | a_wr), 32'h0);
    tick();
    chk("t6_post_wr",    32'(a_wr),     32'h0);
    chk("t6_post_cnt",   32'(a_cnt),    32'h0);
    chk("t6_post_err",   32'(a_err),    32'h0);
    // channels must be back in IDLE: a fresh request on ch0 is accepted
    a_rd = 4'b0001;
    tick();
    a_rd = 4'b0000;
    chk("t6_idle_pipe",  32'(a_pipe_o), 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
